// File: rtl/writeback_unit.sv
// Write-side master for the integer register file: arbitrates ALU/load results into a FIFO,
// drives the single write port and tracks pending writes. Optional macro: WB_BYPASS_EN.
module writeback_unit #(
   parameter int XLEN       = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int DEPTH      = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       alu_valid,
   output logic                       alu_ready,
   input  logic [ADDR_WIDTH-1:0]      alu_rd_index,
   input  logic [XLEN-1:0]            alu_result,
   input  logic                       mem_valid,
   output logic                       mem_ready,
   input  logic [ADDR_WIDTH-1:0]      mem_rd_index,
   input  logic [XLEN-1:0]            mem_result,
   input  logic                       wb_hold,
   input  logic                       issue_valid,
   input  logic [ADDR_WIDTH-1:0]      issue_rd_index,
   output logic [ADDR_WIDTH-1:0]      rd_index,
   output logic [XLEN-1:0]            rd,
   output logic                       write_en,
   output logic [2**ADDR_WIDTH-1:0]   busy,
   output logic [$clog2(DEPTH):0]     fifo_count
);

   localparam int AW   = $clog2(DEPTH);
   localparam int NREG = 2**ADDR_WIDTH;

   // Handshake: a producer holds valid/index/data until it sees ready; the transfer
   // happens on the rising edge where valid && ready. mem always wins over alu.

   logic [ADDR_WIDTH-1:0] idx_mem  [DEPTH];
   logic [XLEN-1:0]       data_mem [DEPTH];
   logic [AW:0]           wr_ptr, rd_ptr;
   logic [ADDR_WIDTH-1:0] last_idx, head_idx, in_idx;
   logic [XLEN-1:0]       last_data, head_data, in_data;
   logic                  full, empty, mem_take, alu_take, xfer, pop, push, bypass;
   logic [NREG-1:0]       set_mask, clr_mask, busy_next;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign fifo_count = wr_ptr - rd_ptr;

   // Readies depend only on registered occupancy, so a same-cycle pop never frees a slot.
   assign mem_ready = reset && !full;
   assign alu_ready = reset && !full && !mem_valid;

   assign mem_take = mem_valid && mem_ready;
   assign alu_take = alu_valid && alu_ready;
   assign xfer     = mem_take || alu_take;
   assign in_idx   = mem_take ? mem_rd_index : alu_rd_index;
   assign in_data  = mem_take ? mem_result   : alu_result;

   assign head_idx  = idx_mem[rd_ptr[AW-1:0]];
   assign head_data = data_mem[rd_ptr[AW-1:0]];
   assign pop       = !empty && !wb_hold;

`ifdef WB_BYPASS_EN
   assign bypass = empty && !wb_hold && xfer;
`else
   assign bypass = 1'b0;
`endif
   assign push = xfer && !bypass;

   always_comb begin
      rd_index = last_idx;
      rd       = last_data;
      write_en = 1'b0;
      if (!empty) begin
         rd_index = head_idx;
         rd       = head_data;
         write_en = pop && (head_idx != '0);
      end else if (bypass) begin
         rd_index = in_idx;
         rd       = in_data;
         write_en = (in_idx != '0);
      end
   end

   // Issue sets win over commit clears so a newer writer keeps ownership; x0 never pends.
   always_comb begin
      set_mask = '0;
      clr_mask = '0;
      if (issue_valid) set_mask[issue_rd_index] = 1'b1;
      if (write_en)    clr_mask[rd_index]       = 1'b1;
      busy_next    = (busy & ~clr_mask) | set_mask;
      busy_next[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (push) begin
         idx_mem[wr_ptr[AW-1:0]]  <= in_idx;
         data_mem[wr_ptr[AW-1:0]] <= in_data;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         last_idx  <= '0;
         last_data <= '0;
         busy      <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (!empty || bypass) begin
            last_idx  <= rd_index;
            last_data <= rd;
         end
         busy <= busy_next;
      end
   end

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: expected writes are queued at acceptance and a
// negedge monitor compares every write_en cycle against the queue head.
module tb_writeback_unit;

   logic        clk;
   logic        reset;
   logic        alu_valid, alu_ready, mem_valid, mem_ready;
   logic [4:0]  alu_rd_index, mem_rd_index, issue_rd_index, rd_index;
   logic [31:0] alu_result, mem_result, rd, busy;
   logic        wb_hold, issue_valid, write_en;
   logic [2:0]  fifo_count;

   logic [36:0] exp_q[$];
   int n_vec  = 0;
   int n_fail = 0;

   writeback_unit #(.XLEN(32), .ADDR_WIDTH(5), .DEPTH(4)) dut (
      .clk(clk), .reset(reset),
      .alu_valid(alu_valid), .alu_ready(alu_ready),
      .alu_rd_index(alu_rd_index), .alu_result(alu_result),
      .mem_valid(mem_valid), .mem_ready(mem_ready),
      .mem_rd_index(mem_rd_index), .mem_result(mem_result),
      .wb_hold(wb_hold), .issue_valid(issue_valid), .issue_rd_index(issue_rd_index),
      .rd_index(rd_index), .rd(rd), .write_en(write_en),
      .busy(busy), .fifo_count(fifo_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every committing write must match the oldest expected write.
   always @(negedge clk) begin
      if (write_en === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_write", {27'd0, rd_index, rd}, 64'hFFFF_FFFF_FFFF_FFFF);
         end else begin
            logic [36:0] e;
            e = exp_q.pop_front();
            check("write_data", {27'd0, rd_index, rd}, {27'd0, e});
         end
      end
   end

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic send_alu(input logic [4:0] idx, input logic [31:0] d, input bit expect_write);
      bit ok;
      alu_valid = 1'b1; alu_rd_index = idx; alu_result = d;
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         ok = alu_ready;
         @(posedge clk);
         if (ok && expect_write && idx != 5'd0) exp_q.push_back({idx, d});
         #1;
      end
      alu_valid = 1'b0;
      if (!ok) check("alu_accept_timeout", 64'd0, 64'd1);
   endtask

   task automatic issue(input logic [4:0] idx);
      issue_valid = 1'b1; issue_rd_index = idx;
      @(posedge clk); #1;
      issue_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b0;
      alu_valid = 0; alu_rd_index = 0; alu_result = 0;
      mem_valid = 0; mem_rd_index = 0; mem_result = 0;
      wb_hold = 0; issue_valid = 0; issue_rd_index = 0;
      alu_valid = 1'b1;
      #2;
      check("rst_fifo_count", fifo_count, 0);
      check("rst_busy", busy, 0);
      check("rst_write_en", write_en, 0);
      check("rst_rd", rd, 0);
      check("rst_rd_index", rd_index, 0);
      check("rst_alu_ready", alu_ready, 0);
      check("rst_mem_ready", mem_ready, 0);
      alu_valid = 1'b0;
      #20 reset = 1'b1;
      @(posedge clk); #1;

      // Single write with 1-cycle latency and busy clear on commit
      issue(5'd5);
      check("busy5_set", busy[5], 1);
      send_alu(5'd5, 32'hDEADBEEF, 1);
      @(negedge clk);
      check("single_we", write_en, 1);
      check("single_idx", rd_index, 5);
      check("single_rd", rd, 32'hDEADBEEF);
      check("single_cnt_during", fifo_count, 1);
      @(posedge clk); #1;
      check("single_cnt_after", fifo_count, 0);
      check("busy5_clear", busy[5], 0);
      check("hold_last_rd", rd, 32'hDEADBEEF);

      // mem priority over alu
      mem_valid = 1; mem_rd_index = 5'd3; mem_result = 32'h3333_3333;
      alu_valid = 1; alu_rd_index = 5'd4; alu_result = 32'h4444_4444;
      @(negedge clk);
      check("prio_mem_ready", mem_ready, 1);
      check("prio_alu_ready", alu_ready, 0);
      @(posedge clk);
      exp_q.push_back({5'd3, 32'h3333_3333});
      #1 mem_valid = 0;
      send_alu(5'd4, 32'h4444_4444, 1);
      @(negedge clk);
      check("prio_second_idx", rd_index, 4);
      idle(2);

      // x0 drop
      send_alu(5'd0, 32'h1234, 1);
      idle(3);
      check("x0_cnt", fifo_count, 0);
      check("x0_busy", busy, 0);

      // Full / hold
      wb_hold = 1'b1;
      for (int i = 0; i < 4; i++) send_alu(5'(10 + i), 32'hA000_0000 + i, 1);
      alu_valid = 1; alu_rd_index = 5'd14; alu_result = 32'hA000_0004;
      @(negedge clk);
      check("full_cnt", fifo_count, 4);
      check("full_alu_ready", alu_ready, 0);
      check("full_mem_ready", mem_ready, 0);
      check("hold_we", write_en, 0);
      @(posedge clk); #1;
      wb_hold = 1'b0;
      send_alu(5'd14, 32'hA000_0004, 1);
      idle(6);
      check("drain_cnt", fifo_count, 0);

      // Scoreboard collision: issue wins over same-edge commit
      issue(5'd7);
      send_alu(5'd7, 32'h77, 1);
      issue_valid = 1; issue_rd_index = 5'd7;
      @(negedge clk);
      check("coll_we", write_en, 1);
      @(posedge clk); #1;
      issue_valid = 0;
      check("coll_busy7", busy[7], 1);
      issue(5'd0);
      check("x0_issue_busy0", busy[0], 0);

      // Async reset mid-burst
      wb_hold = 1'b1;
      issue(5'd9);
      send_alu(5'd9, 32'h9, 0);
      send_alu(5'd10, 32'hA, 0);
      send_alu(5'd11, 32'hB, 0);
      check("pre_rst_cnt", fifo_count, 3);
      #2 reset = 1'b0;
      #1;
      check("arst_cnt", fifo_count, 0);
      check("arst_busy", busy, 0);
      check("arst_we", write_en, 0);
      wb_hold = 1'b0;
      idle(2);
      #3 reset = 1'b1;
      idle(5);
      check("post_rst_cnt", fifo_count, 0);
      check("exp_q_empty", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
